// File: rtl/vram_pkg.sv
// Shared types and SRAM timing constants for the VRAM arbiter.
package vram_pkg;
  localparam int ACCESS_CYCLES = 2;
  localparam int ADR_W = 18;
  localparam int DAT_W = 16;

  typedef enum logic [2:0] {
    IDLE, FETCH_A, FETCH_D, CPU_A, CPU_D, FL_A, FL_D
  } state_t;

  // Arbitration happens whenever the bus is free to start a new ADDR cycle.
  function automatic logic is_boundary(state_t s);
    return (s == IDLE) || (s == FETCH_D) || (s == CPU_D) || (s == FL_D);
  endfunction
endpackage

// File: rtl/vram_lb_packer.sv
// Packs fetched 16-bit words into 32-bit linebuffer writes and owns lbw_adr.
module vram_lb_packer
  import vram_pkg::*;
#(
  parameter int LB_WORDS = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_vld,
  input  logic             in_last,
  input  logic [DAT_W-1:0] in_dat,
  output logic [8:0]       lbw_adr,
  output logic [31:0]      lbw_dat,
  output logic             lbw_we,
  output logic             done
);
  logic             phase_q, phase_d;
  logic [DAT_W-1:0] lo_q, lo_d;
  logic [8:0]       adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             we_q, we_d;
  logic             last_q, last_d;

  always_comb begin
    phase_d = phase_q;
    lo_d    = lo_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = 1'b0;
    last_d  = 1'b0;
    if (we_q) adr_d = (adr_q == 9'(LB_WORDS - 1)) ? 9'd0 : adr_q + 9'd1;
    if (start) begin
      adr_d   = 9'd0;
      phase_d = 1'b0;
    end
    if (in_vld) begin
      if (!phase_q) begin
        lo_d    = in_dat;
        phase_d = 1'b1;
        // An odd-length fetch flushes its final even word alone.
        if (in_last) begin
          dat_d   = {{DAT_W{1'b0}}, in_dat};
          we_d    = 1'b1;
          last_d  = 1'b1;
          phase_d = 1'b0;
        end
      end else begin
        dat_d   = {in_dat, lo_q};
        we_d    = 1'b1;
        last_d  = in_last;
        phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      lo_q    <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      lo_q    <= lo_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      last_q  <= last_d;
    end
  end

  assign lbw_adr = adr_q;
  assign lbw_dat = dat_q;
  assign lbw_we  = we_q;
  assign done    = we_q & last_q;
endmodule

// File: rtl/vram_arbiter.sv
// Single-port SRAM arbiter: line fetch > flash loader > CPU, with CPU fairness.
// Define VRAM_ARB_FLASH_EN to enable the flash-loader write port.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FAIR_N   = 8,
  parameter int LB_WORDS = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_start,
  input  logic [ADR_W-1:0] fetch_base,
  input  logic [9:0]       fetch_len,
  output logic             fetch_busy,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [DAT_W-1:0] cpu_dat_i,
  output logic             cpu_ack,
  output logic [DAT_W-1:0] cpu_dat_o,
  input  logic             fl_req,
  input  logic [ADR_W-1:0] fl_adr,
  input  logic [DAT_W-1:0] fl_dat,
  output logic             fl_ack,
  output logic [ADR_W-1:0] v_adr,
  output logic [DAT_W-1:0] v_dat_o,
  input  logic [DAT_W-1:0] v_dat_i,
  output logic             v_we,
  output logic             v_oe_sram,
  output logic             v_oe_pin,
  output logic [8:0]       lbw_adr,
  output logic [31:0]      lbw_dat,
  output logic             lbw_we
);
  localparam int FW = $clog2(FAIR_N + 1);
  localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_N);

  state_t           state_q, state_d;
  logic [ADR_W-1:0] v_adr_q, v_adr_d, fadr_q, fadr_d, eff_adr;
  logic [DAT_W-1:0] v_dat_o_q, v_dat_o_d, cpu_dat_q, cpu_dat_d;
  logic             v_we_q, v_we_d, v_oe_sram_q, v_oe_sram_d, v_oe_pin_q, v_oe_pin_d;
  logic             cpu_ack_q, cpu_ack_d, fl_ack_q, fl_ack_d, busy_q, busy_d;
  logic [9:0]       rem_q, rem_d, eff_rem;
  logic [FW-1:0]    fair_q, fair_d;
  logic             start_ok, cpu_want, fl_want, lb_done;

  assign start_ok = fetch_start && !busy_q && (fetch_len != 10'd0);
  assign eff_rem  = start_ok ? fetch_len  : rem_q;
  assign eff_adr  = start_ok ? fetch_base : fadr_q;
  // A request still high while its own access completes or acks is not new.
  assign cpu_want = cpu_req && (state_q != CPU_D) && !cpu_ack_q;

`ifdef VRAM_ARB_FLASH_EN
  assign fl_want = fl_req && (state_q != FL_D) && !fl_ack_q;
  assign fl_ack  = fl_ack_q;
`else
  logic unused_fl;
  assign unused_fl = fl_req ^ fl_ack_q;
  assign fl_want   = 1'b0;
  assign fl_ack    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    v_adr_d     = v_adr_q;
    v_dat_o_d   = v_dat_o_q;
    v_we_d      = 1'b0;
    v_oe_sram_d = 1'b1;
    v_oe_pin_d  = 1'b0;
    cpu_ack_d   = 1'b0;
    fl_ack_d    = 1'b0;
    cpu_dat_d   = cpu_dat_q;
    fadr_d      = fadr_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    fair_d      = fair_q;

    if (start_ok) begin
      busy_d = 1'b1;
      rem_d  = fetch_len;
      fadr_d = fetch_base;
    end else if (lb_done) begin
      busy_d = 1'b0;
    end

    case (state_q)
      FETCH_A: state_d = FETCH_D;
      CPU_A: begin
        state_d = CPU_D;
        if (cpu_we) begin
          v_we_d      = 1'b1;
          v_oe_pin_d  = 1'b1;
          v_oe_sram_d = 1'b0;
        end
      end
      FL_A: begin
        state_d     = FL_D;
        v_we_d      = 1'b1;
        v_oe_pin_d  = 1'b1;
        v_oe_sram_d = 1'b0;
      end
      CPU_D: begin
        cpu_ack_d = 1'b1;
        if (!cpu_we) cpu_dat_d = v_dat_i;
      end
      FL_D:    fl_ack_d = 1'b1;
      default: ;
    endcase

    if (is_boundary(state_q)) begin
      if (cpu_want && (fair_q == FAIR_MAX)) begin
        state_d   = CPU_A;
        v_adr_d   = cpu_adr;
        v_dat_o_d = cpu_dat_i;
        fair_d    = '0;
      end else if (eff_rem != 10'd0) begin
        state_d = FETCH_A;
        v_adr_d = eff_adr;
        fadr_d  = eff_adr + ADR_W'(1);
        rem_d   = eff_rem - 10'd1;
        if (fair_q != FAIR_MAX) fair_d = fair_q + 1'b1;
      end else if (fl_want) begin
        state_d   = FL_A;
        v_adr_d   = fl_adr;
        v_dat_o_d = fl_dat;
        fair_d    = '0;
      end else if (cpu_want) begin
        state_d   = CPU_A;
        v_adr_d   = cpu_adr;
        v_dat_o_d = cpu_dat_i;
        fair_d    = '0;
      end else begin
        state_d = IDLE;
        fair_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      v_adr_q     <= '0;
      v_dat_o_q   <= '0;
      v_we_q      <= 1'b0;
      v_oe_sram_q <= 1'b1;
      v_oe_pin_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      fl_ack_q    <= 1'b0;
      cpu_dat_q   <= '0;
      fadr_q      <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      fair_q      <= '0;
    end else begin
      state_q     <= state_d;
      v_adr_q     <= v_adr_d;
      v_dat_o_q   <= v_dat_o_d;
      v_we_q      <= v_we_d;
      v_oe_sram_q <= v_oe_sram_d;
      v_oe_pin_q  <= v_oe_pin_d;
      cpu_ack_q   <= cpu_ack_d;
      fl_ack_q    <= fl_ack_d;
      cpu_dat_q   <= cpu_dat_d;
      fadr_q      <= fadr_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      fair_q      <= fair_d;
    end
  end

  // rem_q already counts the final word as issued while it is in FETCH_D.
  vram_lb_packer #(.LB_WORDS(LB_WORDS)) u_packer (
    .clk     (clk),
    .rst     (rst),
    .start   (start_ok),
    .in_vld  (state_q == FETCH_D),
    .in_last (rem_q == 10'd0),
    .in_dat  (v_dat_i),
    .lbw_adr (lbw_adr),
    .lbw_dat (lbw_dat),
    .lbw_we  (lbw_we),
    .done    (lb_done)
  );

  assign fetch_busy = busy_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_dat_o  = cpu_dat_q;
  assign v_adr      = v_adr_q;
  assign v_dat_o    = v_dat_o_q;
  assign v_we       = v_we_q;
  assign v_oe_sram  = v_oe_sram_q;
  assign v_oe_pin   = v_oe_pin_q;
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter FAIR_N, default 8: the number of fetch accesses after which one pending CPU access is serviced.
REQ-002 SHALL have parameter LB_WORDS, default 512: the linebuffer depth in 32-bit words.
REQ-003 clk  in  1  sole clock; vdp clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 fetch_start  in  1  pulse; begins a line fetch.
REQ-006 fetch_base  in  18  SRAM word address of the line; sampled at fetch_start.
REQ-007 fetch_len  in  10  number of 16-bit words to fetch, 1..1023; sampled at fetch_start.
REQ-008 fetch_busy  out  1  high while a fetch is in progress.
REQ-009 cpu_req, cpu_we, cpu_adr[17:0], cpu_dat_i[15:0]  in  CPU request port, held stable until ack.
REQ-010 cpu_ack  out  1, cpu_dat_o  out  16  ack is a one-cycle pulse; cpu_dat_o is valid with ack on reads.
REQ-011 fl_req, fl_adr[17:0], fl_dat[15:0]  in; fl_ack  out  1  flash-loader write port (see Configuration).
REQ-012 v_adr  out  18, v_dat_o  out  16, v_dat_i  in  16, v_we  out  1, v_oe_sram  out  1, v_oe_pin  out  1  external SRAM bus.
REQ-013 lbw_adr  out  9, lbw_dat  out  32, lbw_we  out  1  linebuffer write port.

Function
REQ-014 SHALL sequence every SRAM access in 2 cycles: ADDR (address driven) then DATA (read captures v_dat_i at the end of the cycle; a write asserts v_we with v_oe_pin=1 and v_oe_sram=0).
REQ-015 SHALL keep v_oe_sram=1 and v_oe_pin=0 except during write DATA cycles, and SHALL never assert v_we and v_oe_sram together.
REQ-016 SHALL implement the states IDLE, FETCH_A, FETCH_D, CPU_A, CPU_D, FL_A, FL_D.
REQ-017 SHALL arbitrate at each access boundary with the priority fetch > flash > CPU, except that after FAIR_N consecutive fetch accesses a pending cpu_req wins one access.
REQ-018 SHALL service back-to-back accesses with no idle cycle between them.
REQ-019 SHALL treat fetch word k as address fetch_base+k, with 18-bit wrap-around from 3FFFF to 00000.
REQ-020 SHALL place even fetch words in lbw_dat[15:0] and odd words in lbw_dat[31:16], pulsing lbw_we for one cycle once the odd word is captured.
REQ-021 SHALL, when fetch_len is odd, write the final word with its upper half zero.
REQ-022 SHALL start lbw_adr at 0 for each fetch, increment it after each write, and wrap it modulo LB_WORDS.
REQ-023 SHALL ignore fetch_start while fetch_busy is high; a fetch_len of 0 SHALL be a no-op that leaves fetch_busy low.
REQ-024 SHALL drop fetch_busy in the cycle after the final lbw_we pulse.
REQ-025 SHALL pulse cpu_ack in the cycle after CPU_D, with a CPU read latency of 3 cycles from grant; cpu_req held high after an ack SHALL be treated as a new request.
REQ-026 SHALL pulse fl_ack in the cycle after FL_D.

Reset
REQ-027 SHALL, on rst, enter IDLE and drive outputs to v_we=0, v_oe_sram=1, v_oe_pin=0, v_adr=0, v_dat_o=0, all acks 0, lbw_we=0, lbw_adr=0, fetch_busy=0, and clear the fairness counter.
REQ-028 SHALL, on rst mid-access, abort the access with no ack and no lbw_we; rst SHALL take priority over all inputs.

Configuration
REQ-029 With VRAM_ARB_FLASH_EN defined, the flash port SHALL be arbitrated as in REQ-017.
REQ-030 Without VRAM_ARB_FLASH_EN, fl_req SHALL be ignored, fl_ack SHALL be tied to 0, and FL_A/FL_D SHALL be unreachable.

Structure
REQ-031 SHALL place the state encoding and the SRAM timing constants (ACCESS_CYCLES=2) in the shared package vram_pkg.
REQ-032 SHALL implement the word-pair packing and lbw_adr counter as the sub-module vram_lb_packer.

Verification
REQ-033 Fetch with base=00010, len=4 and SRAM[n]=n -> lbw writes {0011,0010}@0 and {0013,0012}@1; fetch_busy is high for 9 cycles.
REQ-034 Fetch with base=3FFFF, len=3 -> reads 3FFFF, 00000, 00001; last lbw_dat={0000,SRAM[00001]}.
REQ-035 CPU read 00100 (=BEEF) while idle -> cpu_ack 3 cycles after req with cpu_dat_o=BEEF; CPU write 00100=1234 followed by a read returns 1234.
REQ-036 Fetch len=20 with cpu_req pending from start -> CPU access granted after exactly the 8th fetch access; fetch data is intact.
REQ-037 rst asserted during CPU_D of a write -> no cpu_ack, v_we=0 next cycle, state IDLE.
REQ-038 Simultaneous fl_req and cpu_req with VRAM_ARB_FLASH_EN defined -> flash acked first; without it, fl_ack never asserts.
